rom_port_arbiter: RTL and testbench

Shares the single program/sound ROM dpram port between the main CPU fetch path, the sound CPU fetch path and the HPS ROM download writer. It sits between `mcr1` and the `dpram` instance in the emu top level and replaces the fixed address muxing there with a sequenced request/acknowledge scheduler. The goal is one physical memory port for all three clients.

---
 rtl/rom_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one program/sound ROM memory port between the
// main CPU fetch path, the sound CPU fetch path and the ROM download writer.
// Reads are scheduled by a small IDLE/RD/WR sequencer. Pending download bytes
// win over reads. CPU and sound tie-break round-robin.
// Optional feature macro: ROM_ARB_HIT_EN. It adds a per-port last-address
// hit path that answers a repeated read from the held data without a memory
// access.
module rom_port_arbiter #(
    parameter int              AW       = 16,
    parameter int              DW       = 8,
    parameter int              CPU_AW   = 15,
    parameter int              SND_AW   = 14,
    parameter logic [AW-1:0]   SND_BASE = 16'h8000,
    parameter int              READ_LAT = 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    // main CPU read port
    input  logic              cpu_req,
    input  logic [CPU_AW-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic [DW-1:0]     cpu_q,
    // sound CPU read port
    input  logic              snd_req,
    input  logic [SND_AW-1:0] snd_addr,
    output logic              snd_ack,
    output logic [DW-1:0]     snd_q,
    // ROM download writer
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [24:0]       dl_addr,
    input  logic [DW-1:0]     dl_data,
    output logic              dl_ovf,
    // shared memory port
    output logic [AW-1:0]     mem_addr,
    output logic              mem_we,
    output logic [DW-1:0]     mem_d,
    input  logic [DW-1:0]     mem_q
);

    if (READ_LAT < 1 || READ_LAT > 3) begin : g_lat_check
        $error("rom_port_arbiter: READ_LAT must be 1..3");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    // Last RD count: mem_addr is presented for READ_LAT cycles, then one
    // more cycle lets mem_q settle into the capture register.
    localparam logic [1:0] RD_LAST = 2'(READ_LAT);

    // Sequencer state
    state_t            state_q, state_d;
    logic              last_q, last_d;       // 0 = CPU served last
    logic              port_q, port_d;       // 0 = CPU, 1 = sound
    logic [1:0]        cnt_q, cnt_d;

    // Registered memory port
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DW-1:0]     mem_d_q, mem_d_d;

    // Read port results
    logic              cpu_ack_q, cpu_ack_d;
    logic              snd_ack_q, snd_ack_d;
    logic [DW-1:0]     cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]     snd_rdata_q, snd_rdata_d;

    // One-entry download write buffer
    logic              buf_vld_q, buf_vld_d;
    logic [AW-1:0]     buf_addr_q, buf_addr_d;
    logic [DW-1:0]     buf_data_q, buf_data_d;
    logic              ovf_q, ovf_d;
    logic              buf_clr;

    // Request decode
    logic [AW-1:0]     cpu_maddr;
    logic [AW-1:0]     snd_maddr;
    logic              dl_load;
    logic              rd_ok;
    logic              cpu_pend;
    logic              snd_pend;
    logic              grant_snd;
    logic              rd_done;

    assign cpu_maddr = {{(AW-CPU_AW){1'b0}}, cpu_addr};
    assign snd_maddr = SND_BASE | {{(AW-SND_AW){1'b0}}, snd_addr};

    // Bytes beyond the memory window are dropped without touching the buffer.
    assign dl_load   = dl_wr && (dl_addr[24:AW] == '0);

    // The cycle carrying an ack never grants a read, so a requester that
    // keeps req high is seen as a fresh request one cycle later.
    assign rd_ok     = !dl_active && !cpu_ack_q && !snd_ack_q;
    assign cpu_pend  = cpu_req && rd_ok;
    assign snd_pend  = snd_req && rd_ok;
    assign grant_snd = snd_pend && (!cpu_pend || !last_q);
    assign rd_done   = (state_q == ST_RD) && (cnt_q == RD_LAST);

`ifdef ROM_ARB_HIT_EN
    logic              cpu_hv_q, cpu_hv_d;
    logic              snd_hv_q, snd_hv_d;
    logic [CPU_AW-1:0] cpu_la_q, cpu_la_d;
    logic [SND_AW-1:0] snd_la_q, snd_la_d;
    logic              dl_active_q;
    logic              cpu_hit;
    logic              snd_hit;

    assign cpu_hit = cpu_hv_q && (cpu_la_q == cpu_addr);
    assign snd_hit = snd_hv_q && (snd_la_q == snd_addr);
`endif

    // Sequencer next state, memory port and read-port results
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        port_d      = port_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_d_d     = mem_d_q;
        cpu_ack_d   = 1'b0;
        snd_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        snd_rdata_d = snd_rdata_q;
        buf_clr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (buf_vld_q) begin
                    mem_addr_d = buf_addr_q;
                    mem_d_d    = buf_data_q;
                    mem_we_d   = 1'b1;
                    state_d    = ST_WR;
                end else if (cpu_pend || snd_pend) begin
                    port_d  = grant_snd;
                    cnt_d   = 2'd0;
                    state_d = ST_RD;
                    if (grant_snd) begin
                        mem_addr_d = snd_maddr;
                    end else begin
                        mem_addr_d = cpu_maddr;
                    end
`ifdef ROM_ARB_HIT_EN
                    // A repeat of the port's last completed address is
                    // answered from the held data; the memory port is left alone.
                    if (grant_snd && snd_hit) begin
                        snd_ack_d  = 1'b1;
                        last_d     = 1'b1;
                        mem_addr_d = mem_addr_q;
                        state_d    = ST_IDLE;
                    end else if (!grant_snd && cpu_hit) begin
                        cpu_ack_d  = 1'b1;
                        last_d     = 1'b0;
                        mem_addr_d = mem_addr_q;
                        state_d    = ST_IDLE;
                    end
`endif
                end
            end

            ST_RD: begin
                if (cnt_q == RD_LAST) begin
                    if (port_q) begin
                        snd_rdata_d = mem_q;
                        snd_ack_d   = 1'b1;
                        last_d      = 1'b1;
                    end else begin
                        cpu_rdata_d = mem_q;
                        cpu_ack_d   = 1'b1;
                        last_d      = 1'b0;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end

            ST_WR: begin
                buf_clr = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write buffer load, drain and sticky overflow
    always_comb begin
        buf_vld_d  = buf_vld_q && !buf_clr;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        ovf_d      = ovf_q;
        if (dl_load) begin
            // A byte landing while the buffer drains takes the freed slot.
            if (buf_vld_d) begin
                ovf_d = 1'b1;
            end else begin
                buf_vld_d  = 1'b1;
                buf_addr_d = dl_addr[AW-1:0];
                buf_data_d = dl_data;
            end
        end
    end

    // Sequencer, memory port, read results and buffer registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            port_q      <= 1'b0;
            cnt_q       <= 2'd0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_d_q     <= '0;
            cpu_ack_q   <= 1'b0;
            snd_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            snd_rdata_q <= '0;
            buf_vld_q   <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            port_q      <= port_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_d_q     <= mem_d_d;
            cpu_ack_q   <= cpu_ack_d;
            snd_ack_q   <= snd_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            snd_rdata_q <= snd_rdata_d;
            buf_vld_q   <= buf_vld_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef ROM_ARB_HIT_EN
    // Hit tracking: remember each port's last completed address; any write
    // or the start of a download invalidates both entries.
    always_comb begin
        cpu_hv_d = cpu_hv_q;
        snd_hv_d = snd_hv_q;
        cpu_la_d = cpu_la_q;
        snd_la_d = snd_la_q;
        if (rd_done) begin
            if (port_q) begin
                snd_hv_d = 1'b1;
                snd_la_d = snd_addr;
            end else begin
                cpu_hv_d = 1'b1;
                cpu_la_d = cpu_addr;
            end
        end
        if ((state_q == ST_WR) || (dl_active && !dl_active_q)) begin
            cpu_hv_d = 1'b0;
            snd_hv_d = 1'b0;
        end
    end

    // Hit tracking registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cpu_hv_q    <= 1'b0;
            snd_hv_q    <= 1'b0;
            cpu_la_q    <= '0;
            snd_la_q    <= '0;
            dl_active_q <= 1'b0;
        end else begin
            cpu_hv_q    <= cpu_hv_d;
            snd_hv_q    <= snd_hv_d;
            cpu_la_q    <= cpu_la_d;
            snd_la_q    <= snd_la_d;
            dl_active_q <= dl_active;
        end
    end
`endif

    assign cpu_ack  = cpu_ack_q;
    assign cpu_q    = cpu_rdata_q;
    assign snd_ack  = snd_ack_q;
    assign snd_q    = snd_rdata_q;
    assign dl_ovf   = ovf_q;
    assign mem_addr = mem_addr_q;
    assign mem_we   = mem_we_q;
    assign mem_d    = mem_d_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter (READ_LAT=1) with a behavioural one-cycle ROM.
module tb_rom_port_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic        cpu_req = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_q;
    logic        snd_req = 1'b0;
    logic [13:0] snd_addr = '0;
    logic        snd_ack;
    logic [7:0]  snd_q;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [24:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        dl_ovf;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_d;
    logic [7:0]  mem_q_r = '0;

    int total = 0;
    int bad   = 0;

    rom_port_arbiter #(
        .AW(16), .DW(8), .CPU_AW(15), .SND_AW(14),
        .SND_BASE(16'h8000), .READ_LAT(1)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_q(cpu_q),
        .snd_req(snd_req), .snd_addr(snd_addr), .snd_ack(snd_ack), .snd_q(snd_q),
        .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_ovf(dl_ovf),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q_r)
    );

    always #5 clk_sys = ~clk_sys;

    // Behavioural ROM: preloaded once, then written by mem_we, read latency 1.
    logic [7:0] mem [0:65535];
    bit         mem_init_done = 1'b0;
    always @(posedge clk_sys) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
            mem[16'h0000] <= 8'h0F;
            mem[16'h0042] <= 8'h11;
            mem[16'h0100] <= 8'hB1;
            mem[16'h1234] <= 8'h5A;
            mem[16'h7FFF] <= 8'hEE;
            mem[16'h8000] <= 8'h77;
            mem[16'h8010] <= 8'h3C;
            mem[16'h8020] <= 8'h4D;
            mem[16'hBFFF] <= 8'h99;
            mem_init_done <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_d;
        end
        mem_q_r <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    // One read: request at a negedge, check mem_addr one cycle later,
    // cycles to ack and the returned data.
    task automatic do_read(input bit is_snd, input logic [15:0] addr,
                           input logic [15:0] exp_maddr, input logic [7:0] exp_q,
                           input int exp_lat);
        int          k;
        bit          got;
        logic [15:0] ma1;
        logic [7:0]  q;
        k = 0; got = 0; ma1 = '0; q = '0;
        @(negedge clk_sys);
        if (is_snd) begin
            snd_addr = addr[13:0];
            snd_req  = 1'b1;
        end else begin
            cpu_addr = addr[14:0];
            cpu_req  = 1'b1;
        end
        while (!got && k < 20) begin
            @(negedge clk_sys);
            k++;
            if (k == 1) ma1 = mem_addr;
            if (is_snd ? snd_ack : cpu_ack) begin
                got = 1;
                q   = is_snd ? snd_q : cpu_q;
            end
        end
        cpu_req = 1'b0;
        snd_req = 1'b0;
        check(is_snd ? "snd_maddr" : "cpu_maddr", 32'(ma1), 32'(exp_maddr));
        check(is_snd ? "snd_lat" : "cpu_lat", k, exp_lat);
        check(is_snd ? "snd_q" : "cpu_q", 32'(q), 32'(exp_q));
    endtask

    typedef struct {
        bit          snd;
        logic [15:0] addr;
        logic [15:0] maddr;
        logic [7:0]  q;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int          ksnd, kwe, kc, nwe, cpu_bad, k;
        logic [15:0] wea;
        logic [7:0]  wed, sq, cq;
        logic [15:0] cpu_hist, snd_hist;
        logic [15:0] ma_cpu, ma_snd;

        tbl[0] = '{1'b0, 16'h1234, 16'h1234, 8'h5A};
        tbl[1] = '{1'b0, 16'h0042, 16'h0042, 8'h11};
        tbl[2] = '{1'b0, 16'h7FFF, 16'h7FFF, 8'hEE};
        tbl[3] = '{1'b1, 16'h0010, 16'h8010, 8'h3C};
        tbl[4] = '{1'b1, 16'h0000, 16'h8000, 8'h77};
        tbl[5] = '{1'b1, 16'h3FFF, 16'hBFFF, 8'h99};

        // Reset values
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_snd_ack", 32'(snd_ack), 32'd0);
        check("rst_cpu_q", 32'(cpu_q), 32'd0);
        check("rst_snd_q", 32'(snd_q), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_d", 32'(mem_d), 32'd0);
        check("rst_dl_ovf", 32'(dl_ovf), 32'd0);
        reset_n = 1'b1;

        // Single reads on both ports, full latency READ_LAT+2
        for (int i = 0; i < 6; i++)
            do_read(tbl[i].snd, tbl[i].addr, tbl[i].maddr, tbl[i].q, 3);

        // Simultaneous requests out of reset: CPU first, then alternating
        do_reset();
        @(negedge clk_sys);
        cpu_addr = 15'h0042; cpu_req = 1'b1;
        snd_addr = 14'h0010; snd_req = 1'b1;
        cpu_hist = '0; snd_hist = '0; ma_cpu = '0; ma_snd = '0; cq = '0; sq = '0;
        for (int kk = 1; kk <= 16; kk++) begin
            @(negedge clk_sys);
            if (kk == 1) ma_cpu = mem_addr;
            if (kk == 5) ma_snd = mem_addr;
            if (cpu_ack) begin cpu_hist[kk] = 1'b1; cq = cpu_q; end
            if (snd_ack) begin snd_hist[kk] = 1'b1; sq = snd_q; end
        end
        cpu_req = 1'b0; snd_req = 1'b0;
        check("tie_cpu_maddr", 32'(ma_cpu), 32'h0042);
        check("tie_snd_maddr", 32'(ma_snd), 32'h8010);
`ifdef ROM_ARB_HIT_EN
        check("tie_cpu_acks", 32'(cpu_hist), 32'h2208);
        check("tie_snd_acks", 32'(snd_hist), 32'h8880);
`else
        check("tie_cpu_acks", 32'(cpu_hist), 32'h0808);
        check("tie_snd_acks", 32'(snd_hist), 32'h8080);
`endif
        check("tie_cpu_q", 32'(cq), 32'h11);
        check("tie_snd_q", 32'(sq), 32'h3C);

        // Download during a sound read; CPU blocked while dl_active
        @(negedge clk_sys);
        snd_addr = 14'h0000; snd_req = 1'b1;
        ksnd = 0; sq = '0; kwe = 0; nwe = 0; cpu_bad = 0; wea = '0; wed = '0;
        for (int kk = 1; kk <= 12; kk++) begin
            @(negedge clk_sys);
            if (kk == 1) begin
                dl_active = 1'b1; dl_wr = 1'b1; dl_addr = 25'h3; dl_data = 8'hC3;
                cpu_addr = 15'h1234; cpu_req = 1'b1;
            end
            if (kk == 2) dl_wr = 1'b0;
            if (snd_ack) begin ksnd = kk; sq = snd_q; snd_req = 1'b0; end
            if (mem_we) begin nwe++; kwe = kk; wea = mem_addr; wed = mem_d; end
            if (cpu_ack) cpu_bad++;
        end
        check("dl_snd_lat", ksnd, 3);
        check("dl_snd_q", 32'(sq), 32'h77);
        check("dl_we_count", nwe, 1);
        check("dl_we_cycle", kwe, 4);
        check("dl_we_addr", 32'(wea), 32'h0003);
        check("dl_we_data", 32'(wed), 32'hC3);
        check("dl_cpu_blocked", cpu_bad, 0);
        dl_active = 1'b0;
        k = 0;
        while (!cpu_ack && k < 10) begin @(negedge clk_sys); k++; end
        check("dl_cpu_lat", k, 3);
        check("dl_cpu_q", 32'(cpu_q), 32'h5A);
        cpu_req = 1'b0;
        do_read(1'b0, 16'h0003, 16'h0003, 8'hC3, 3);

        // Out-of-range download byte is dropped
        @(negedge clk_sys);
        dl_wr = 1'b1; dl_addr = 25'h10000; dl_data = 8'hFF;
        nwe = 0;
        for (int kk = 1; kk <= 6; kk++) begin
            @(negedge clk_sys);
            if (kk == 1) dl_wr = 1'b0;
            if (mem_we) nwe++;
        end
        check("oor_we_count", nwe, 0);
        check("oor_ovf", 32'(dl_ovf), 32'd0);
        do_read(1'b0, 16'h0000, 16'h0000, 8'h0F, 3);

        // Two back-to-back strobes during a read: first written, overflow set
        @(negedge clk_sys);
        cpu_addr = 15'h7FFF; cpu_req = 1'b1;
        kc = 0; cq = '0; nwe = 0; wea = '0; wed = '0;
        for (int kk = 1; kk <= 8; kk++) begin
            @(negedge clk_sys);
            if (kk == 1) begin dl_wr = 1'b1; dl_addr = 25'h5; dl_data = 8'h55; end
            if (kk == 2) begin dl_addr = 25'h6; dl_data = 8'h66; end
            if (kk == 3) dl_wr = 1'b0;
            if (cpu_ack) begin kc = kk; cq = cpu_q; cpu_req = 1'b0; end
            if (mem_we) begin nwe++; wea = mem_addr; wed = mem_d; end
        end
        check("ovf_cpu_lat", kc, 3);
        check("ovf_cpu_q", 32'(cq), 32'hEE);
        check("ovf_we_count", nwe, 1);
        check("ovf_we_addr", 32'(wea), 32'h0005);
        check("ovf_we_data", 32'(wed), 32'h55);
        check("ovf_flag", 32'(dl_ovf), 32'd1);
        repeat (4) @(negedge clk_sys);
        check("ovf_sticky", 32'(dl_ovf), 32'd1);
        do_read(1'b0, 16'h0006, 16'h0006, 8'h00, 3);
        do_read(1'b0, 16'h0005, 16'h0005, 8'h55, 3);

        // Reset mid-read: asynchronous clear, no ack afterwards
        @(negedge clk_sys);
        cpu_addr = 15'h1234; cpu_req = 1'b1;
        @(negedge clk_sys);
        reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("arst_mem_addr", 32'(mem_addr), 32'd0);
        check("arst_dl_ovf", 32'(dl_ovf), 32'd0);
        check("arst_cpu_q", 32'(cpu_q), 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        nwe = 0;
        for (int kk = 1; kk <= 6; kk++) begin
            @(negedge clk_sys);
            if (cpu_ack || snd_ack || mem_we) nwe++;
        end
        check("arst_no_ack", nwe, 0);
        do_read(1'b0, 16'h0042, 16'h0042, 8'h11, 3);

`ifdef ROM_ARB_HIT_EN
        // Hit path: repeat address acked next cycle, write invalidates
        do_reset();
        do_read(1'b0, 16'h0100, 16'h0100, 8'hB1, 3);
        do_read(1'b1, 16'h0020, 16'h8020, 8'h4D, 3);
        do_read(1'b0, 16'h0100, 16'h8020, 8'hB1, 1);
        @(negedge clk_sys);
        dl_wr = 1'b1; dl_addr = 25'h100; dl_data = 8'hB2;
        @(negedge clk_sys);
        dl_wr = 1'b0;
        repeat (5) @(negedge clk_sys);
        do_read(1'b0, 16'h0100, 16'h0100, 8'hB2, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
